// File: rtl/lcd_pkg.sv
// Shared constants for the ST7920 value display: controller command bytes, the
// ASCII codes used on the line, and the main/bus FSM state encodings.
// No ports; imported by lcd_value_display.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h30;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;
  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_SP      = 8'h20;

  typedef enum logic [2:0] {
    StPwrup, StInit, StAddr, StLatch, StConv, StChar, StDone
  } main_state_e;

  // One byte write walks Setup -> High -> Hold -> Gap, then returns to Idle.
  typedef enum logic [2:0] {
    PhIdle, PhSetup, PhHigh, PhHold, PhGap
  } bus_phase_e;

  // Init command issued at position idx of the power-up sequence.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_8BIT;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_INC;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports: clk, rst_n (async active-low), i_start (accepted only when idle),
//        i_value (binary in), o_done (one-cycle pulse when o_bcd is valid),
//        o_bcd (DEC_DIGITS packed BCD nibbles, most significant digit on top).
// Latency: load cycle plus VALUE_W shift cycles; o_bcd holds until the next start.
module bin2bcd_seq #(
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned DEC_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [VALUE_W-1:0]      i_value,
  output logic                    o_done,
  output logic [4*DEC_DIGITS-1:0] o_bcd
);

  logic                    r_busy;
  logic                    r_done;
  logic [4:0]              r_cnt;
  logic [VALUE_W-1:0]      r_bin;
  logic [4*DEC_DIGITS-1:0] r_bcd;
  logic [4*DEC_DIGITS-1:0] w_adj;

  // Add-3 correction on every digit that would overflow past 9 after the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DEC_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_bin  <= i_value;
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
      end else begin
        r_bcd <= {w_adj[4*DEC_DIGITS-2:0], r_bin[VALUE_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'(VALUE_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/lcd_value_display.sv
// ST7920 8-bit parallel writer showing one unsigned value on a single text line.
// Build option: LCD_VALUE_DISPLAY_DEC_EN adds the BCD converter and decimal output;
// without it dec_mode is ignored and the value is always shown in binary.
// Ports: clk, rst_n (async active-low), value/dec_mode (sampled once per frame),
//        frame_done (pulse after a frame's last char), lcd_rs/lcd_rw/lcd_en/lcd_dat/
//        lcd_psb/lcd_rst_n (LCD pins, all registered or tied).
module lcd_value_display
  import lcd_pkg::*;
#(
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned TICK_CYC   = 16,
  parameter int unsigned BYTE_GAP   = 4000,
  parameter int unsigned CLR_GAP    = 100000,
  parameter int unsigned PWRUP_CYC  = 2000000,
  parameter logic [6:0]  LINE_ADDR  = 7'h00,
  parameter int unsigned DEC_DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               dec_mode,
  output logic               frame_done,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic [7:0]         lcd_dat,
  output logic               lcd_psb,
  output logic               lcd_rst_n
);

  localparam logic [7:0] AddrCmd = CMD_DDRAM | {1'b0, LINE_ADDR};

  main_state_e        r_state, w_state_nxt;
  bus_phase_e         r_phase, w_phase_nxt;
  logic [31:0]        r_cnt, w_cnt_nxt, w_gap;
  logic [4:0]         r_idx, w_idx_nxt, w_nchars;
  logic [VALUE_W-1:0] r_bin, w_bin_nxt;
  logic               r_lead, w_lead_nxt;
  logic               r_rs, r_en, r_frame_done, r_lcd_rst_n;
  logic [7:0]         r_dat;
  logic               w_launch, w_launch_rs, w_byte_done;
  logic [7:0]         w_launch_dat;

`ifdef LCD_VALUE_DISPLAY_DEC_EN
  logic                    r_dec, w_dec_nxt;
  logic [4*DEC_DIGITS-1:0] r_bcd, w_bcd_nxt, w_bcd;
  logic                    w_conv_start, w_conv_done;
  logic [8:0]              w_dc;

  // Returns {still_leading, char}: leading zeros blank, the last digit always prints.
  function automatic logic [8:0] dec_char(input logic lead, input logic [3:0] nib,
                                          input logic last);
    logic blank;
    blank = lead && (nib == 4'd0) && !last;
    return {blank, blank ? ASCII_SP : (ASCII_0 | {4'd0, nib})};
  endfunction

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_conv_start),
    .i_value (r_bin),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  assign w_nchars = r_dec ? 5'(DEC_DIGITS) : 5'(VALUE_W);
`else
  logic w_unused_dec;
  assign w_unused_dec = dec_mode;
  assign w_nchars     = 5'(VALUE_W);
`endif

  // rs/dat stay on the bus through Hold and Gap, so they still identify the last byte.
  assign w_gap = (!r_rs && r_dat == CMD_CLEAR) ? CLR_GAP : BYTE_GAP;

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_cnt_nxt    = r_cnt + 32'd1;
    w_idx_nxt    = r_idx;
    w_bin_nxt    = r_bin;
    w_lead_nxt   = r_lead;
    w_launch     = 1'b0;
    w_launch_rs  = 1'b0;
    w_launch_dat = 8'h00;
    w_byte_done  = 1'b0;
`ifdef LCD_VALUE_DISPLAY_DEC_EN
    w_dec_nxt    = r_dec;
    w_bcd_nxt    = r_bcd;
    w_conv_start = 1'b0;
    w_dc         = '0;
`endif

    case (r_phase)
      PhSetup: if (r_cnt == TICK_CYC - 1) begin w_phase_nxt = PhHigh; w_cnt_nxt = '0; end
      PhHigh:  if (r_cnt == TICK_CYC - 1) begin w_phase_nxt = PhHold; w_cnt_nxt = '0; end
      PhHold:  if (r_cnt == TICK_CYC - 1) begin w_phase_nxt = PhGap;  w_cnt_nxt = '0; end
      PhGap: begin
        if (r_cnt == w_gap - 1) begin
          w_phase_nxt = PhIdle;
          w_cnt_nxt   = '0;
          w_byte_done = 1'b1;
        end
      end
      default: ;  // Idle: free-running count serves the power-up wait
    endcase

    case (r_state)
      StPwrup: begin
        if (r_cnt == PWRUP_CYC - 1) begin
          w_state_nxt  = StInit;
          w_idx_nxt    = '0;
          w_launch     = 1'b1;
          w_launch_dat = init_cmd(2'd0);
        end
      end
      StInit: begin
        if (w_byte_done) begin
          w_launch = 1'b1;
          if (r_idx == 5'd3) begin
            w_state_nxt  = StAddr;
            w_launch_dat = AddrCmd;
          end else begin
            w_idx_nxt    = r_idx + 5'd1;
            w_launch_dat = init_cmd(w_idx_nxt[1:0]);
          end
        end
      end
      StAddr: if (w_byte_done) w_state_nxt = StLatch;
      StLatch: begin
        w_lead_nxt = 1'b1;
        w_idx_nxt  = '0;
        w_bin_nxt  = value;
`ifdef LCD_VALUE_DISPLAY_DEC_EN
        w_dec_nxt  = dec_mode;
        if (dec_mode) begin
          w_state_nxt  = StConv;
          w_conv_start = 1'b1;
        end else
`endif
        begin
          // First char comes straight from the input being captured this cycle.
          w_state_nxt  = StChar;
          w_launch     = 1'b1;
          w_launch_rs  = 1'b1;
          w_launch_dat = ASCII_0 | {7'd0, value[VALUE_W-1]};
          w_bin_nxt    = value << 1;
        end
      end
`ifdef LCD_VALUE_DISPLAY_DEC_EN
      StConv: begin
        if (w_conv_done) begin
          w_dc         = dec_char(r_lead, w_bcd[4*DEC_DIGITS-1 -: 4], DEC_DIGITS == 1);
          w_lead_nxt   = w_dc[8];
          w_bcd_nxt    = w_bcd << 4;
          w_state_nxt  = StChar;
          w_launch     = 1'b1;
          w_launch_rs  = 1'b1;
          w_launch_dat = w_dc[7:0];
        end
      end
`endif
      StChar: begin
        if (w_byte_done) begin
          if (r_idx == w_nchars - 5'd1) begin
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_launch    = 1'b1;
            w_launch_rs = 1'b1;
`ifdef LCD_VALUE_DISPLAY_DEC_EN
            if (r_dec) begin
              w_dc = dec_char(r_lead, r_bcd[4*DEC_DIGITS-1 -: 4],
                              w_idx_nxt == w_nchars - 5'd1);
              w_lead_nxt   = w_dc[8];
              w_bcd_nxt    = r_bcd << 4;
              w_launch_dat = w_dc[7:0];
            end else
`endif
            begin
              w_launch_dat = ASCII_0 | {7'd0, r_bin[VALUE_W-1]};
              w_bin_nxt    = r_bin << 1;
            end
          end
        end
      end
      StDone: begin
        w_state_nxt  = StAddr;
        w_launch     = 1'b1;
        w_launch_dat = AddrCmd;
      end
      default: ;
    endcase

    if (w_launch) begin
      w_phase_nxt = PhSetup;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StPwrup;
      r_phase      <= PhIdle;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_bin        <= '0;
      r_lead       <= 1'b1;
      r_rs         <= 1'b0;
      r_dat        <= 8'h00;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
      r_lcd_rst_n  <= 1'b0;
`ifdef LCD_VALUE_DISPLAY_DEC_EN
      r_dec        <= 1'b0;
      r_bcd        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_bin        <= w_bin_nxt;
      r_lead       <= w_lead_nxt;
      if (w_launch) begin
        r_rs  <= w_launch_rs;
        r_dat <= w_launch_dat;
      end
      r_en         <= (w_phase_nxt == PhHigh);
      r_frame_done <= (w_state_nxt == StDone);
      // Held low for the first TICK_CYC cycles after reset release, then sticky high.
      r_lcd_rst_n  <= r_lcd_rst_n | (r_cnt >= TICK_CYC - 1);
`ifdef LCD_VALUE_DISPLAY_DEC_EN
      r_dec        <= w_dec_nxt;
      r_bcd        <= w_bcd_nxt;
`endif
    end
  end

  assign frame_done = r_frame_done;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = r_en;
  assign lcd_dat    = r_dat;
  assign lcd_psb    = 1'b1;
  assign lcd_rst_n  = r_lcd_rst_n;

endmodule

// File: tb/tb_lcd_value_display.sv
module tb_lcd_value_display;

  localparam int unsigned VALUE_W = 16;
  localparam int unsigned TICK    = 2;
  localparam int unsigned BGAP    = 20;
  localparam int unsigned CGAP    = 60;
  localparam int unsigned PWR     = 100;
  localparam int unsigned DD      = 5;
  localparam int unsigned BUDGET  = 3000;
`ifdef LCD_VALUE_DISPLAY_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [15:0]  value = 16'h0000;
  logic         dec_mode = 1'b0;
  logic         frame_done, lcd_rs, lcd_rw, lcd_en, lcd_psb, lcd_rst_n;
  logic [7:0]   lcd_dat;

  always #5 clk = ~clk;

  lcd_value_display #(
    .VALUE_W    (VALUE_W),
    .TICK_CYC   (TICK),
    .BYTE_GAP   (BGAP),
    .CLR_GAP    (CGAP),
    .PWRUP_CYC  (PWR),
    .LINE_ADDR  (7'h00),
    .DEC_DIGITS (DD)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dec_mode   (dec_mode),
    .frame_done (frame_done),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_dat    (lcd_dat),
    .lcd_psb    (lcd_psb),
    .lcd_rst_n  (lcd_rst_n)
  );

  typedef struct packed {
    logic        rs;
    logic [7:0]  dat;
    logic [31:0] high;
    logic [31:0] gap;
    logic [31:0] fall;
  } obs_t;

  obs_t        obs_q[$];
  logic [8:0]  exp_q[$];
  logic [31:0] fd_q[$];
  logic [31:0] fd_len_q[$];

  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  int unsigned last_addr_fall = 0;
  int          checks = 0;
  int          errors = 0;

  // Bus model: logs rs/dat at each en fall plus timing, and frame_done pulses.
  logic        prev_en = 1'b0, prev_fd = 1'b0;
  int unsigned rise_cyc = 0, last_fall = 0, fd_start = 0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      prev_en   = 1'b0;
      prev_fd   = 1'b0;
      last_fall = cyc;
    end else begin
      if (lcd_en && !prev_en) rise_cyc = cyc;
      if (!lcd_en && prev_en) begin
        obs_q.push_back('{rs: lcd_rs, dat: lcd_dat, high: cyc - rise_cyc,
                          gap: rise_cyc - last_fall, fall: cyc});
        last_fall = cyc;
      end
      if (frame_done && !prev_fd) fd_start = cyc;
      if (!frame_done && prev_fd) begin
        fd_q.push_back(fd_start);
        fd_len_q.push_back(cyc - fd_start);
      end
      prev_en = lcd_en;
      prev_fd = frame_done;
    end
  end

  // Reference model for one frame's characters.
  task automatic push_frame(input logic [15:0] v, input logic dec);
    logic [7:0]  ch[DD];
    int unsigned x;
    if (dec) begin
      x = v;
      for (int i = DD - 1; i >= 0; i--) begin
        ch[i] = 8'h30 + 8'(x % 10);
        x     = x / 10;
      end
      for (int i = 0; i < DD - 1; i++) begin
        if (ch[i] == 8'h30) ch[i] = 8'h20;
        else break;
      end
      for (int i = 0; i < DD; i++) exp_q.push_back({1'b1, ch[i]});
    end else begin
      for (int i = VALUE_W - 1; i >= 0; i--) exp_q.push_back({1'b1, v[i] ? 8'h31 : 8'h30});
    end
  endtask

  task automatic pop_obs(output bit got, output obs_t o);
    got = 1'b0;
    o   = '0;
    for (int i = 0; i < BUDGET; i++) begin
      if (obs_q.size() != 0) break;
      @(posedge clk);
      #2;
    end
    if (obs_q.size() != 0) begin
      got = 1'b1;
      o   = obs_q.pop_front();
    end
  endtask

  task automatic test_reset();
    value    = 16'hA5C3;
    dec_mode = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (lcd_en !== 1'b0)     begin errors++; $display("FAIL reset_en: got %b want 0", lcd_en); end
    if (lcd_rs !== 1'b0)     begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
    if (lcd_dat !== 8'h00)   begin errors++; $display("FAIL reset_dat: got %h want 00", lcd_dat); end
    if (lcd_rw !== 1'b0)     begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
    if (lcd_psb !== 1'b1)    begin errors++; $display("FAIL reset_psb: got %b want 1", lcd_psb); end
    if (lcd_rst_n !== 1'b0)  begin errors++; $display("FAIL reset_lcd_rst_n: got %b want 0", lcd_rst_n); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    @(posedge clk); #2;
    checks++;
    if (lcd_rst_n !== 1'b0) begin errors++; $display("FAIL lcd_rst_n_early: got %b want 0", lcd_rst_n); end
    @(posedge clk); #2;
    checks++;
    if (lcd_rst_n !== 1'b1) begin errors++; $display("FAIL lcd_rst_n_rise: got %b want 1", lcd_rst_n); end
  endtask

  task automatic test_init();
    bit         got;
    obs_t       o;
    logic [8:0] e, prev;
    int         k;
    exp_q.push_back(9'h030);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h080);
    k    = 0;
    prev = 9'h000;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(got, o);
      checks++;
      if (!got) begin
        errors++; $display("FAIL init_byte%0d: timeout, want %h", k, e); exp_q.delete();
      end else begin
        if ({o.rs, o.dat} !== e) begin
          errors++; $display("FAIL init_byte%0d: got %h want %h", k, {o.rs, o.dat}, e);
        end
        checks++;
        if (o.high != TICK) begin
          errors++; $display("FAIL init_en_high%0d: got %0d want %0d", k, o.high, TICK);
        end
        checks++;
        if (k == 0) begin
          if (o.fall - rel_cyc < PWR) begin
            errors++; $display("FAIL pwrup_delay: got %0d want >=%0d", o.fall - rel_cyc, PWR);
          end
        end else if (o.gap < ((prev == 9'h001) ? CGAP : BGAP)) begin
          errors++; $display("FAIL init_gap%0d: got %0d want >=%0d", k, o.gap,
                             (prev == 9'h001) ? CGAP : BGAP);
        end
        if (k == 4) last_addr_fall = o.fall;
      end
      prev = e;
      k++;
    end
  endtask

  task automatic test_binary();
    bit          got;
    obs_t        o;
    logic [8:0]  e;
    int          k;
    int unsigned last_char_fall;
    fd_q.delete();
    fd_len_q.delete();
    push_frame(16'hA5C3, 1'b0);
    exp_q.push_back(9'h080);
    k = 0;
    last_char_fall = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(got, o);
      checks++;
      if (!got) begin
        errors++; $display("FAIL bin_byte%0d: timeout, want %h", k, e); exp_q.delete();
      end else begin
        if ({o.rs, o.dat} !== e) begin
          errors++; $display("FAIL bin_byte%0d: got %h want %h", k, {o.rs, o.dat}, e);
        end
        checks++;
        if (o.high != TICK || o.gap < BGAP) begin
          errors++; $display("FAIL bin_timing%0d: high %0d gap %0d want %0d/>=%0d",
                             k, o.high, o.gap, TICK, BGAP);
        end
        if (k == VALUE_W - 1) last_char_fall = o.fall;
        if (k == VALUE_W) begin
          checks++;
          if (o.fall - last_addr_fall != (1 + VALUE_W) * (3 * TICK + BGAP) + 2) begin
            errors++; $display("FAIL frame_period: got %0d want %0d", o.fall - last_addr_fall,
                               (1 + VALUE_W) * (3 * TICK + BGAP) + 2);
          end
          checks++;
          if (fd_q.size() == 0) begin
            errors++; $display("FAIL frame_done_seen: got 0 pulses want 1");
          end else if (fd_q[0] <= last_char_fall || fd_q[0] >= o.fall || fd_len_q[0] != 1) begin
            errors++; $display("FAIL frame_done_pos: got start %0d len %0d want in (%0d,%0d) len 1",
                               fd_q[0], fd_len_q[0], last_char_fall, o.fall);
          end
          last_addr_fall = o.fall;
        end
      end
      k++;
    end
  endtask

  task automatic test_mid_change();
    bit         got;
    obs_t       o;
    logic [8:0] e;
    int         k;
    push_frame(16'hA5C3, 1'b0);
    exp_q.push_back(9'h080);
    push_frame(16'h3C01, 1'b0);
    exp_q.push_back(9'h080);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(got, o);
      checks++;
      if (!got) begin
        errors++; $display("FAIL mid_byte%0d: timeout, want %h", k, e); exp_q.delete();
      end else if ({o.rs, o.dat} !== e) begin
        errors++; $display("FAIL mid_byte%0d: got %h want %h", k, {o.rs, o.dat}, e);
      end
      if (k == 2) value = 16'h3C01;
      k++;
    end
  endtask

  task automatic test_decimal();
    bit          got;
    obs_t        o;
    logic [8:0]  e;
    logic [15:0] vals[3];
    vals[0] = 16'd65535;
    vals[1] = 16'd7;
    vals[2] = 16'd0;
    for (int t = 0; t < 3; t++) begin
      value    = vals[t];
      dec_mode = 1'b1;
      push_frame(vals[t], DEC_EN);
      exp_q.push_back(9'h080);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pop_obs(got, o);
        checks++;
        if (!got) begin
          errors++; $display("FAIL dec_%0d: timeout, want %h", vals[t], e); exp_q.delete();
        end else if ({o.rs, o.dat} !== e) begin
          errors++; $display("FAIL dec_%0d: got %h want %h", vals[t], {o.rs, o.dat}, e);
        end
      end
    end
    dec_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit         got;
    obs_t       o;
    logic [8:0] e;
    int         k;
    value = 16'h0001;
    for (int i = 0; i < BUDGET; i++) begin
      if (lcd_en === 1'b1) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (lcd_en !== 1'b1) begin errors++; $display("FAIL rst_mid_en_wait: got %b want 1", lcd_en); end
    #1 rst_n = 1'b0;
    #1;
    checks += 2;
    if (lcd_en !== 1'b0)    begin errors++; $display("FAIL rst_mid_en: got %b want 0", lcd_en); end
    if (lcd_rst_n !== 1'b0) begin errors++; $display("FAIL rst_mid_lcd_rst_n: got %b want 0", lcd_rst_n); end
    repeat (2) @(posedge clk);
    obs_q.delete();
    fd_q.delete();
    fd_len_q.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    exp_q.push_back(9'h030);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h080);
    push_frame(16'h0001, 1'b0);
    exp_q.push_back(9'h080);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_obs(got, o);
      checks++;
      if (!got) begin
        errors++; $display("FAIL reinit_byte%0d: timeout, want %h", k, e); exp_q.delete();
      end else begin
        if ({o.rs, o.dat} !== e) begin
          errors++; $display("FAIL reinit_byte%0d: got %h want %h", k, {o.rs, o.dat}, e);
        end
        if (k == 0) begin
          checks++;
          if (o.fall - rel_cyc < PWR) begin
            errors++; $display("FAIL repwrup_delay: got %0d want >=%0d", o.fall - rel_cyc, PWR);
          end
        end
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_binary();
    test_mid_change();
    test_decimal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
